ads131_frame_unpacker: RTL and testbench

//  Downstream of the ADS131A0X SPI frame engine. Takes the word stream clocked out of the ADC
//  on each DRDY frame: 1 status word, NUM_CH channel words, optional CRC word.

---
 rtl/ads131_pkg.sv | 34 +++
 rtl/ads131_sample_fifo.sv | 55 +++++
 rtl/ads131_frame_unpacker.sv | 187 ++++++++++++++++++
 tb/tb_ads131_frame_unpacker.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ads131_pkg.sv
// Shared definitions for the ADS131A0x frame unpacker.
//   STAT_1_HDR : expected top byte of the STAT_1 status word
//   MAX_CH     : widest supported frame (A04)
//   state_e    : unpacker FSM states
//   sext24/sext16 : sign extension of a channel word to 32 bits
//   sat_add8   : saturating 8-bit counter increment
package ads131_pkg;

    localparam logic [7:0]  STAT_1_HDR = 8'h22;
    localparam int unsigned MAX_CH     = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STATUS = 3'd1,
        CHAN   = 3'd2,
        CRC    = 3'd3,
        COMMIT = 3'd4
    } state_e;

    function automatic logic [31:0] sext24(input logic [23:0] d);
        return {{8{d[23]}}, d};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] d);
        return {{16{d[15]}}, d};
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/ads131_sample_fifo.sv
// First-word-fall-through sample FIFO.
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_push, i_push_data  : write strobe and entry
//   i_pop_ready          : consumer accepts head when o_valid is high
//   o_valid, o_data      : head entry (o_data forced to 0 while empty)
//   o_free               : number of free entries
module ads131_sample_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 35
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop_ready,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_free
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = (r_count != '0) && i_pop_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_free  = (AW+1)'(DEPTH) - r_count;

endmodule

// File: rtl/ads131_frame_unpacker.sv
// Unpacks ADS131A0x DRDY frames (status, NUM_CH channel words, optional CRC) into a sample
// stream. Frames are staged and only committed whole, so a consumer never sees a partial frame.
//   i_system_clock, i_reset_n         : clock, async active-low reset
//   i_frame_start, i_frame_abort      : frame delimiters from the SPI engine
//   i_word_valid, i_word_data         : received word strobe and data
//   o_sample_valid/i_sample_ready     : output handshake
//   o_sample_data/ch/last             : sign-extended sample, channel, end-of-frame flag
//   o_status_word                     : top 16 bits of the last committed status word
//   o_hdr_err_cnt, o_ovf_cnt          : saturating drop counters
module ads131_frame_unpacker
    import ads131_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned WORD_BITS  = 24,
    parameter bit          CRC_EN     = 1'b0,
    parameter logic [7:0]  STATUS_HDR = STAT_1_HDR,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 i_system_clock,
    input  logic                 i_reset_n,
    input  logic                 i_frame_start,
    input  logic                 i_frame_abort,
    input  logic                 i_word_valid,
    input  logic [WORD_BITS-1:0] i_word_data,
    output logic                 o_sample_valid,
    input  logic                 i_sample_ready,
    output logic [31:0]          o_sample_data,
    output logic [1:0]           o_sample_ch,
    output logic                 o_sample_last,
    output logic [15:0]          o_status_word,
    output logic [7:0]           o_hdr_err_cnt,
    output logic [7:0]           o_ovf_cnt
);

    localparam int unsigned FREE_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0]  LAST_CH = 2'(NUM_CH - 1);

    state_e      r_state, w_state_d;
    logic [1:0]  r_ch_idx, w_ch_idx_d;
    logic [1:0]  r_push_idx, w_push_idx_d, w_push_idx;
    logic        r_first, w_first_d;
    logic [31:0] r_stage [MAX_CH];
    logic [15:0] r_stat_stage;
    logic [15:0] r_status_word;
    logic [7:0]  r_hdr_err_cnt;
    logic [7:0]  r_ovf_cnt;

    logic              w_start, w_hdr_ok, w_fits;
    logic              w_stage_we, w_stat_we, w_status_upd, w_push, w_ovf_inc;
    logic [1:0]        w_hdr_inc;
    logic [31:0]       w_sample;
    logic [34:0]       w_push_data, w_fifo_data;
    logic [FREE_W-1:0] w_free;
    logic              w_unused_pad;

    // 32-bit words carry 24-bit data MSB-aligned with a pad byte below.
    if (WORD_BITS == 16) begin : g_w16
        assign w_sample = sext16(i_word_data[15:0]);
    end else begin : g_w24
        assign w_sample = sext24(i_word_data[WORD_BITS-1 -: 24]);
    end
    assign w_unused_pad = ^i_word_data;

    assign w_start     = i_word_valid && i_frame_start;
    assign w_hdr_ok    = (i_word_data[WORD_BITS-1 -: 8] == STATUS_HDR);
    assign w_fits      = (w_free >= FREE_W'(NUM_CH));
    assign w_push_idx  = r_first ? 2'd0 : r_push_idx;
    assign w_push_data = {(w_push_idx == LAST_CH), w_push_idx, r_stage[w_push_idx]};

    always_comb begin
        w_state_d    = r_state;
        w_ch_idx_d   = r_ch_idx;
        w_push_idx_d = r_push_idx;
        w_first_d    = 1'b0;
        w_stage_we   = 1'b0;
        w_stat_we    = 1'b0;
        w_status_upd = 1'b0;
        w_push       = 1'b0;
        w_ovf_inc    = 1'b0;
        w_hdr_inc    = 2'd0;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    if (w_hdr_ok) begin
                        w_stat_we  = 1'b1;
                        w_ch_idx_d = 2'd0;
                        w_state_d  = CHAN;
                    end else begin
                        w_hdr_inc = 2'd1;
                    end
                end
            end
            CHAN, CRC: begin
                if (w_start) begin
                    // New frame started over an unfinished one: drop it, restart on this word.
                    if (w_hdr_ok) begin
                        w_hdr_inc  = 2'd1;
                        w_stat_we  = 1'b1;
                        w_ch_idx_d = 2'd0;
                        w_state_d  = CHAN;
                    end else begin
                        w_hdr_inc = 2'd2;
                        w_state_d = IDLE;
                    end
                end else if (i_frame_abort) begin
                    w_hdr_inc = 2'd1;
                    w_state_d = IDLE;
                end else if (i_word_valid) begin
                    if (r_state == CRC) begin
                        w_state_d = COMMIT;
                        w_first_d = 1'b1;
                    end else begin
                        w_stage_we = 1'b1;
                        if (r_ch_idx == LAST_CH) begin
                            w_state_d = CRC_EN ? CRC : COMMIT;
                            w_first_d = !CRC_EN;
                        end else begin
                            w_ch_idx_d = r_ch_idx + 2'd1;
                        end
                    end
                end
            end
            COMMIT: begin
                if (i_word_valid) w_hdr_inc = 2'd1;
                if (r_first && !w_fits) begin
                    w_ovf_inc = 1'b1;
                    w_state_d = IDLE;
                end else begin
                    w_push = 1'b1;
                    if (w_push_idx == LAST_CH) begin
                        w_status_upd = 1'b1;
                        w_state_d    = IDLE;
                    end else begin
                        w_push_idx_d = w_push_idx + 2'd1;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_system_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= IDLE;
            r_ch_idx      <= '0;
            r_push_idx    <= '0;
            r_first       <= 1'b0;
            r_stat_stage  <= '0;
            r_status_word <= '0;
            r_hdr_err_cnt <= '0;
            r_ovf_cnt     <= '0;
            for (int i = 0; i < MAX_CH; i++) r_stage[i] <= '0;
        end else begin
            r_state    <= w_state_d;
            r_ch_idx   <= w_ch_idx_d;
            r_push_idx <= w_push_idx_d;
            r_first    <= w_first_d;
            if (w_stage_we)   r_stage[r_ch_idx] <= w_sample;
            if (w_stat_we)    r_stat_stage <= i_word_data[WORD_BITS-1 -: 16];
            if (w_status_upd) r_status_word <= r_stat_stage;
            r_hdr_err_cnt <= sat_add8(r_hdr_err_cnt, w_hdr_inc);
            r_ovf_cnt     <= sat_add8(r_ovf_cnt, {1'b0, w_ovf_inc});
        end
    end

    ads131_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (35)
    ) u_fifo (
        .i_clk       (i_system_clock),
        .i_rst_n     (i_reset_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop_ready (i_sample_ready),
        .o_valid     (o_sample_valid),
        .o_data      (w_fifo_data),
        .o_free      (w_free)
    );

    assign o_sample_last = w_fifo_data[34];
    assign o_sample_ch   = w_fifo_data[33:32];
    assign o_sample_data = w_fifo_data[31:0];
    assign o_status_word = r_status_word;
    assign o_hdr_err_cnt = r_hdr_err_cnt;
    assign o_ovf_cnt     = r_ovf_cnt;

endmodule

// File: tb/tb_ads131_frame_unpacker.sv
`timescale 1ns/1ps
module tb_ads131_frame_unpacker;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #10 clk = ~clk;
    logic rst_n;

    // DUT A: 24-bit words, no CRC
    logic        a_fs, a_fa, a_wv, a_valid, a_ready, a_last, a_ready_fix, a_rr_en, rr_bit;
    logic [23:0] a_wd;
    logic [31:0] a_data;
    logic [1:0]  a_ch;
    logic [15:0] a_stat;
    logic [7:0]  a_hdr, a_ovf;
    assign a_ready = a_rr_en ? rr_bit : a_ready_fix;

    // DUT B: 32-bit words with CRC
    logic        b_fs, b_fa, b_wv, b_valid, b_ready, b_last;
    logic [31:0] b_wd, b_data;
    logic [1:0]  b_ch;
    logic [15:0] b_stat;
    logic [7:0]  b_hdr, b_ovf;

    ads131_frame_unpacker u_dut_a (
        .i_system_clock (clk),     .i_reset_n (rst_n),
        .i_frame_start  (a_fs),    .i_frame_abort (a_fa),
        .i_word_valid   (a_wv),    .i_word_data (a_wd),
        .o_sample_valid (a_valid), .i_sample_ready (a_ready),
        .o_sample_data  (a_data),  .o_sample_ch (a_ch), .o_sample_last (a_last),
        .o_status_word  (a_stat),  .o_hdr_err_cnt (a_hdr), .o_ovf_cnt (a_ovf)
    );

    ads131_frame_unpacker #(.NUM_CH(4), .WORD_BITS(32), .CRC_EN(1'b1), .FIFO_DEPTH(16)) u_dut_b (
        .i_system_clock (clk),     .i_reset_n (rst_n),
        .i_frame_start  (b_fs),    .i_frame_abort (b_fa),
        .i_word_valid   (b_wv),    .i_word_data (b_wd),
        .o_sample_valid (b_valid), .i_sample_ready (b_ready),
        .o_sample_data  (b_data),  .o_sample_ch (b_ch), .o_sample_last (b_last),
        .o_status_word  (b_stat),  .o_hdr_err_cnt (b_hdr), .o_ovf_cnt (b_ovf)
    );

    typedef enum int {KValA, KHdrA, KOvfA, KStatA, KDataA,
                      KValB, KHdrB, KOvfB, KStatB, KTimeout} kind_e;
    typedef struct { kind_e kind; logic [31:0] exp; string name; } req_t;

    req_t        req_q[$];
    logic [34:0] exp_a[$];
    logic [34:0] exp_b[$];
    int          n_tests = 0;
    int          n_fails = 0;

    // Reference model state
    int          m_hdr_a, m_ovf_a, m_hdr_b;
    logic [15:0] m_stat_a, m_stat_b;
    bit          m_part_a;
    logic [23:0] fr [4];
    logic [31:0] frb [4];

    // ---------------- monitor / scoreboard ----------------
    logic [34:0] prev_a;
    bit          stall_a;
    always @(negedge clk) begin
        req_t        r;
        logic [31:0] act;
        logic [34:0] got, e;
        while (req_q.size() > 0) begin
            r = req_q.pop_front();
            n_tests++;
            if (r.kind == KTimeout) begin
                n_fails++;
                $display("FAIL %s: wait bound expired, got no event, required one", r.name);
            end else begin
                case (r.kind)
                    KValA:   act = {31'd0, a_valid};
                    KHdrA:   act = {24'd0, a_hdr};
                    KOvfA:   act = {24'd0, a_ovf};
                    KStatA:  act = {16'd0, a_stat};
                    KDataA:  act = a_data;
                    KValB:   act = {31'd0, b_valid};
                    KHdrB:   act = {24'd0, b_hdr};
                    KOvfB:   act = {24'd0, b_ovf};
                    KStatB:  act = {16'd0, b_stat};
                    default: act = '0;
                endcase
                if (act !== r.exp) begin
                    n_fails++;
                    $display("FAIL %s: got %h, required %h", r.name, act, r.exp);
                end
            end
        end
        if (!rst_n) begin
            stall_a = 1'b0;
        end else begin
            got = {a_last, a_ch, a_data};
            if (stall_a) begin
                n_tests++;
                if (got !== prev_a) begin
                    n_fails++;
                    $display("FAIL stable_a: got %h, required %h", got, prev_a);
                end
            end
            if (a_valid && a_ready) begin
                n_tests++;
                if (exp_a.size() == 0) begin
                    n_fails++;
                    $display("FAIL sample_a: got %h, required no sample", got);
                end else begin
                    e = exp_a.pop_front();
                    if (got !== e) begin
                        n_fails++;
                        $display("FAIL sample_a: got %h, required %h", got, e);
                    end
                end
            end
            stall_a = a_valid && !a_ready;
            prev_a  = got;
            if (b_valid && b_ready) begin
                got = {b_last, b_ch, b_data};
                n_tests++;
                if (exp_b.size() == 0) begin
                    n_fails++;
                    $display("FAIL sample_b: got %h, required no sample", got);
                end else begin
                    e = exp_b.pop_front();
                    if (got !== e) begin
                        n_fails++;
                        $display("FAIL sample_b: got %h, required %h", got, e);
                    end
                end
            end
        end
    end

    initial begin
        rr_bit = 1'b0;
        forever begin
            @(posedge clk);
            #1 rr_bit = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- model helpers ----------------
    function automatic logic [31:0] ref_sext24(input logic [23:0] v);
        int s;
        s = int'(v);
        if (s >= 8388608) s = s - 16777216;
        return 32'(s);
    endfunction

    function automatic int inc_sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input kind_e k, input logic [31:0] e, input string n);
        req_t r;
        r.kind = k; r.exp = e; r.name = n;
        req_q.push_back(r);
    endtask

    task automatic word_a(input logic [23:0] d, input bit st, input int gap);
        a_wv = 1'b1; a_fs = st; a_wd = d;
        tick();
        a_wv = 1'b0; a_fs = 1'b0; a_wd = 24'($urandom);
        repeat (gap) tick();
    endtask

    task automatic word_b(input logic [31:0] d, input bit st, input int gap);
        b_wv = 1'b1; b_fs = st; b_wd = d;
        tick();
        b_wv = 1'b0; b_fs = 1'b0; b_wd = $urandom;
        repeat (gap) tick();
    endtask

    // Predicts the outcome of a frame of nw channel words (4 = complete).
    task automatic model_a(input logic [23:0] stat, input int nw, input bit abort);
        if (m_part_a) begin
            m_hdr_a  = inc_sat(m_hdr_a);
            m_part_a = 1'b0;
        end
        if (stat[23:16] != 8'h22) begin
            m_hdr_a = inc_sat(m_hdr_a);
        end else if (nw == 4) begin
            if (DEPTH - exp_a.size() >= 4) begin
                for (int i = 0; i < 4; i++)
                    exp_a.push_back({(i == 3), 2'(i), ref_sext24(fr[i])});
                m_stat_a = stat[23:8];
            end else begin
                m_ovf_a = inc_sat(m_ovf_a);
            end
        end else if (abort) begin
            m_hdr_a = inc_sat(m_hdr_a);
        end else begin
            m_part_a = 1'b1;
        end
    endtask

    task automatic send_a(input logic [23:0] stat, input int nw, input bit abort,
                          input int last_gap);
        word_a(stat, 1'b1, 2);
        for (int i = 0; i < nw; i++) word_a(fr[i], 1'b0, (i == nw - 1 && !abort) ? last_gap : 2);
        if (abort) begin
            a_fa = 1'b1;
            tick();
            a_fa = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic frame_a(input logic [23:0] stat, input int nw, input bit abort);
        model_a(stat, nw, abort);
        send_a(stat, nw, abort, 8);
    endtask

    task automatic frame_b(input logic [31:0] stat, input bit abort);
        if (abort) begin
            m_hdr_b = inc_sat(m_hdr_b);
        end else begin
            for (int i = 0; i < 4; i++)
                exp_b.push_back({(i == 3), 2'(i), ref_sext24(frb[i][31:8])});
            m_stat_b = stat[31:16];
        end
        word_b(stat, 1'b1, 2);
        for (int i = 0; i < 4; i++) word_b(frb[i], 1'b0, 2);
        if (abort) begin
            b_fa = 1'b1;
            tick();
            b_fa = 1'b0;
            repeat (6) tick();
        end else begin
            word_b($urandom, 1'b0, 8);
        end
    endtask

    task automatic wait_a_below(input int lim, input int budget, input string n);
        int t;
        t = 0;
        while (exp_a.size() > lim && t < budget) begin
            tick();
            t++;
        end
        if (exp_a.size() > lim) post(KTimeout, 32'd0, n);
    endtask

    task automatic wait_b_empty(input int budget, input string n);
        int t;
        t = 0;
        while (exp_b.size() > 0 && t < budget) begin
            tick();
            t++;
        end
        if (exp_b.size() > 0) post(KTimeout, 32'd0, n);
    endtask

    function automatic logic [23:0] pick24();
        case ($urandom_range(0, 5))
            0:       return 24'h7FFFFF;
            1:       return 24'h800000;
            2:       return 24'h000000;
            3:       return 24'hFFFFFF;
            default: return 24'($urandom);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  bad;
        logic [23:0] stat;
        int          kind, nw;
        bit          ab;

        rst_n = 1'b0;
        a_fs = 0; a_fa = 0; a_wv = 0; a_wd = '0; a_ready_fix = 1'b1; a_rr_en = 1'b0;
        b_fs = 0; b_fa = 0; b_wv = 0; b_wd = '0; b_ready = 1'b1;
        m_hdr_a = 0; m_ovf_a = 0; m_hdr_b = 0; m_stat_a = '0; m_stat_b = '0; m_part_a = 0;
        repeat (3) tick();
        post(KValA, 32'd0, "rst_valid_a");
        post(KDataA, 32'd0, "rst_data_a");
        post(KHdrA, 32'd0, "rst_hdr_a");
        post(KOvfA, 32'd0, "rst_ovf_a");
        post(KStatA, 32'd0, "rst_stat_a");
        post(KValB, 32'd0, "rst_valid_b");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Directed frame with sign-boundary samples and latency check
        fr[0] = 24'h7FFFFF; fr[1] = 24'h800000; fr[2] = 24'h000001; fr[3] = 24'hFFFFFF;
        model_a(24'h2200A5, 4, 1'b0);
        send_a(24'h2200A5, 4, 1'b0, 0);
        post(KValA, 32'd0, "latency_commit_cycle");
        tick();
        post(KValA, 32'd1, "latency_fifo_cycle");
        repeat (8) tick();
        post(KStatA, 32'(m_stat_a), "status_word_t1");

        // Bad header then a good frame
        frame_a(24'h0A1234, 4, 1'b0);
        post(KHdrA, 32'(m_hdr_a), "bad_hdr_cnt");
        for (int i = 0; i < 4; i++) fr[i] = pick24();
        frame_a(24'h22BEEF, 4, 1'b0);
        post(KHdrA, 32'(m_hdr_a), "good_after_bad_hdr");

        // Unfinished frame overtaken by a new frame_start
        for (int i = 0; i < 4; i++) fr[i] = pick24();
        frame_a(24'h221111, 2, 1'b0);
        for (int i = 0; i < 4; i++) fr[i] = pick24();
        frame_a(24'h222222, 4, 1'b0);
        post(KHdrA, 32'(m_hdr_a), "restart_cnt");

        // Abort after two channel words, then a good frame
        frame_a(24'h223333, 2, 1'b1);
        post(KHdrA, 32'(m_hdr_a), "abort_cnt");
        for (int i = 0; i < 4; i++) fr[i] = pick24();
        frame_a(24'h224444, 4, 1'b0);
        wait_a_below(0, 200, "drain_directed");
        post(KStatA, 32'(m_stat_a), "status_after_abort");

        // Randomized frames with random backpressure
        a_rr_en = 1'b1;
        repeat (40) begin
            wait_a_below(DEPTH - 8, 300, "random_space");
            kind = $urandom_range(0, 9);
            bad  = 8'($urandom);
            if (bad == 8'h22) bad = 8'h23;
            stat = {(kind == 6) ? bad : 8'h22, 16'($urandom)};
            nw = 4; ab = 1'b0;
            if (kind == 7) begin nw = $urandom_range(0, 3); ab = 1'b1; end
            if (kind == 8) nw = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) fr[i] = pick24();
            frame_a(stat, nw, ab);
        end
        wait_a_below(0, 400, "random_drain");
        post(KHdrA, 32'(m_hdr_a), "random_hdr_cnt");
        post(KOvfA, 32'(m_ovf_a), "random_ovf_cnt");
        post(KStatA, 32'(m_stat_a), "random_status");

        // Overflow: five frames with the consumer stalled
        a_rr_en = 1'b0;
        a_ready_fix = 1'b0;
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 4; i++) fr[i] = 24'($urandom);
            frame_a({8'h22, 16'(f)}, 4, 1'b0);
        end
        post(KOvfA, 32'(m_ovf_a), "ovf_cnt");
        post(KValA, 32'd1, "full_valid");
        tick();
        a_ready_fix = 1'b1;
        wait_a_below(0, 200, "ovf_drain");
        post(KStatA, 32'(m_stat_a), "status_after_ovf");

        // Async reset in the middle of a commit
        a_ready_fix = 1'b0;
        for (int i = 0; i < 4; i++) fr[i] = 24'($urandom);
        word_a(24'h22ABCD, 1'b1, 2);
        for (int i = 0; i < 4; i++) word_a(fr[i], 1'b0, (i == 3) ? 0 : 2);
        repeat (2) tick();
        post(KValA, 32'd1, "mid_commit_valid");
        @(negedge clk);
        #1 rst_n = 1'b0;
        exp_a.delete();
        m_hdr_a = 0; m_ovf_a = 0; m_stat_a = '0; m_part_a = 1'b0;
        m_hdr_b = 0; exp_b.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        a_ready_fix = 1'b1;
        tick();
        post(KValA, 32'd0, "post_rst_valid");
        post(KHdrA, 32'd0, "post_rst_hdr");
        post(KOvfA, 32'd0, "post_rst_ovf");
        post(KStatA, 32'd0, "post_rst_stat");
        repeat (6) tick();
        post(KValA, 32'd0, "no_partial_after_rst");

        // Counter saturation
        for (int f = 0; f < 300; f++) begin
            word_a({8'h0A, 16'(f)}, 1'b1, 1);
            m_hdr_a = inc_sat(m_hdr_a);
        end
        post(KHdrA, 32'(m_hdr_a), "hdr_saturated");
        for (int i = 0; i < 4; i++) fr[i] = pick24();
        frame_a(24'h225A5A, 4, 1'b0);
        wait_a_below(0, 200, "sat_drain");
        post(KHdrA, 32'(m_hdr_a), "hdr_still_saturated");
        post(KStatA, 32'(m_stat_a), "status_after_sat");

        // 32-bit words with CRC
        for (int i = 0; i < 4; i++) frb[i] = 32'h12345600;
        frame_b(32'h22000000, 1'b0);
        wait_b_empty(200, "crc_drain");
        post(KStatB, 32'(m_stat_b), "crc_status");
        post(KHdrB, 32'(m_hdr_b), "crc_hdr_cnt");
        for (int i = 0; i < 4; i++) frb[i] = $urandom;
        frame_b(32'h22770000, 1'b1);
        post(KHdrB, 32'(m_hdr_b), "abort_in_crc_cnt");
        post(KValB, 32'd0, "abort_in_crc_valid");
        repeat (10) begin
            for (int i = 0; i < 4; i++) frb[i] = $urandom;
            frame_b({8'h22, 24'($urandom)}, 1'b0);
        end
        wait_b_empty(200, "random_b_drain");
        post(KStatB, 32'(m_stat_b), "random_b_status");
        post(KOvfB, 32'd0, "random_b_ovf");

        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
